// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin front end that lets two requesters share one sequential
// multiplier. A winner is picked in IDLE and its operands are latched. The
// multiplier is then cleared (LOAD) and started (RUN). When the multiplier
// signals done, the product is captured and returned with a one-cycle
// acknowledge (DONE).
//
// Optional feature: define MULT_SHARE_TIMEOUT_EN to build a RUN watchdog.
// The operation is aborted after TIMEOUT RUN cycles; RESULT is then all ones
// and ERR pulses with the ACK.
//
// Ports
//   CLK               clock, rising edge
//   RESET             synchronous active-high reset
//   REQ0/REQ1         request levels, held until the matching ACK
//   W0/Y0, W1/Y1      requester operands (WIDTH bits)
//   ACK0/ACK1         one-cycle acknowledge, RESULT valid in that cycle
//   RESULT            registered product (2*WIDTH), held until next ACK
//   ERR               timeout flag, coincident with ACK
//   BUSY              high whenever not IDLE
//   M_RESET/M_S       multiplier reset / start
//   M_W/M_Y           multiplier operands
//   M_RESULT/M_PRONTO multiplier product / done
module mult_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ0,
  input  logic               REQ1,
  input  logic [WIDTH-1:0]   W0,
  input  logic [WIDTH-1:0]   Y0,
  input  logic [WIDTH-1:0]   W1,
  input  logic [WIDTH-1:0]   Y1,
  output logic               ACK0,
  output logic               ACK1,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               ERR,
  output logic               BUSY,
  output logic               M_RESET,
  output logic               M_S,
  output logic [WIDTH-1:0]   M_W,
  output logic [WIDTH-1:0]   M_Y,
  input  logic [2*WIDTH-1:0] M_RESULT,
  input  logic               M_PRONTO
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last;
  logic               r_gnt;
  logic [WIDTH-1:0]   r_mw;
  logic [WIDTH-1:0]   r_my;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_busy;
  logic               r_ms;
  logic               r_load;
  logic               w_grant;
  logic               w_gnt_idx;
  logic               w_finish;
  logic               w_timeout;

`ifdef MULT_SHARE_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // RUN cycle counter: cleared while in LOAD so it starts at zero in RUN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_state == ST_LOAD) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Limit hit on the TIMEOUT-th RUN cycle; PRONTO takes priority in the FSM
  assign w_timeout = (r_state == ST_RUN) && (r_cnt == CW'(TIMEOUT - 1));

  // Error flag: a finish without PRONTO can only be a timeout
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_finish && !M_PRONTO;
    end
  end

  assign ERR = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout = 1'b0;
  assign ERR       = 1'b0;
`endif

  // Next-state and arbitration decisions
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_gnt_idx = r_gnt;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          // Tie: serve whoever was not served last
          w_grant   = 1'b1;
          w_gnt_idx = ~r_last;
          w_next    = ST_LOAD;
        end else if (REQ0) begin
          w_grant   = 1'b1;
          w_gnt_idx = 1'b0;
          w_next    = ST_LOAD;
        end else if (REQ1) begin
          w_grant   = 1'b1;
          w_gnt_idx = 1'b1;
          w_next    = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_next = ST_RUN;
      end
      ST_RUN: begin
        // PRONTO is only trusted here; a stale done may linger in IDLE/LOAD
        if (M_PRONTO || w_timeout) begin
          w_finish = 1'b1;
          w_next   = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, operand/result capture, and registered output strobes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_gnt    <= 1'b0;
      r_mw     <= {WIDTH{1'b0}};
      r_my     <= {WIDTH{1'b0}};
      r_result <= {(2*WIDTH){1'b0}};
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_ms     <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt <= w_gnt_idx;
        r_mw  <= w_gnt_idx ? W1 : W0;
        r_my  <= w_gnt_idx ? Y1 : Y0;
      end
      if (w_finish) begin
        r_last   <= r_gnt;
        r_result <= M_PRONTO ? M_RESULT : {(2*WIDTH){1'b1}};
      end
      r_ack0 <= w_finish && !r_gnt;
      r_ack1 <= w_finish && r_gnt;
      r_busy <= (w_next != ST_IDLE);
      r_ms   <= (w_next == ST_RUN);
      r_load <= (w_next == ST_LOAD);
    end
  end

  // Multiplier reset must follow RESET immediately, not a cycle later
  assign M_RESET = RESET || r_load;
  assign M_S     = r_ms;
  assign M_W     = r_mw;
  assign M_Y     = r_my;
  assign ACK0    = r_ack0;
  assign ACK1    = r_ack1;
  assign BUSY    = r_busy;
  assign RESULT  = r_result;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int TB_TO = 16;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REQ0, REQ1;
  logic [7:0]  W0, Y0, W1, Y1;
  logic        ACK0, ACK1, ERR, BUSY, M_RESET, M_S;
  logic [15:0] RESULT;
  logic [7:0]  M_W, M_Y;
  logic [15:0] M_RESULT;
  logic        M_PRONTO;

  int checks = 0;
  int failures = 0;
  bit tb_go = 1'b0;
  int stub_lat = 2;

  mult_share_arbiter #(.WIDTH(8), .TIMEOUT(TB_TO)) dut (
    .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1),
    .W0(W0), .Y0(Y0), .W1(W1), .Y1(Y1),
    .ACK0(ACK0), .ACK1(ACK1), .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY),
    .M_RESET(M_RESET), .M_S(M_S), .M_W(M_W), .M_Y(M_Y),
    .M_RESULT(M_RESULT), .M_PRONTO(M_PRONTO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Stub multiplier: done stub_lat started cycles after reset; done stays high
  // (stale) until the next M_RESET. stub_lat==0 means it never finishes.
  int st_cnt = 0;
  always @(posedge CLK) begin
    if (M_RESET) begin
      st_cnt   <= 0;
      M_PRONTO <= 1'b0;
    end else if (M_S && !M_PRONTO && stub_lat != 0) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == stub_lat) begin
        M_PRONTO <= 1'b1;
        M_RESULT <= 16'(M_W) * 16'(M_Y);
      end
    end
  end

  // Requester queues: each entry is one operation (w,y)
  logic [7:0] qw0[$], qy0[$], qw1[$], qy1[$];

  task automatic drive0();
    if (qw0.size() > 0) begin W0 = qw0[0]; Y0 = qy0[0]; REQ0 = 1'b1; end
    else REQ0 = 1'b0;
  endtask
  task automatic drive1();
    if (qw1.size() > 0) begin W1 = qw1[0]; Y1 = qy1[0]; REQ1 = 1'b1; end
    else REQ1 = 1'b0;
  endtask
  task automatic push(input int r, input logic [7:0] w, input logic [7:0] y);
    if (r == 0) begin qw0.push_back(w); qy0.push_back(y); if (!REQ0) drive0(); end
    else begin qw1.push_back(w); qy1.push_back(y); if (!REQ1) drive1(); end
  endtask

  // Requester behaviour: retire the op on its ACK, present next one or drop REQ
  always @(negedge CLK) begin
    if (ACK0 && REQ0) begin void'(qw0.pop_front()); void'(qy0.pop_front()); drive0(); end
    if (ACK1 && REQ1) begin void'(qw1.pop_front()); void'(qy1.pop_front()); drive1(); end
  end

  // Snapshot of inputs as the DUT saw them at the rising edge
  logic s_reset, s_req0, s_req1;
  logic [7:0] s_w0, s_y0, s_w1, s_y1;
  always @(posedge CLK) begin
    s_reset <= RESET; s_req0 <= REQ0; s_req1 <= REQ1;
    s_w0 <= W0; s_y0 <= Y0; s_w1 <= W1; s_y1 <= Y1;
  end

  // Transaction-level model: fair pick among requests seen at the grant edge,
  // a fixed overhead on top of the multiplier time, product of latched operands.
  int          m_last = 1;
  bit          m_act = 1'b0, m_after = 1'b0, m_to = 1'b0, m_win = 1'b0;
  int          m_n = 0, m_done_n = 0;
  logic [7:0]  m_w, m_y;
  logic [15:0] m_res = 16'd0;

  always @(negedge CLK) begin
    if (tb_go) begin
      if (RESET) chk("m_reset_during_reset", {31'd0, M_RESET}, 32'd1);
      if (s_reset) begin
        m_last = 1; m_act = 1'b0; m_after = 1'b0; m_res = 16'd0;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ack", {30'd0, ACK1, ACK0}, 32'd0);
        chk("rst_result", {16'd0, RESULT}, 32'd0);
      end else begin
        if (m_after) begin
          chk("idle_gap_busy", {31'd0, BUSY}, 32'd0);
          m_after = 1'b0;
        end else if (!m_act && BUSY) begin
          chk("grant_has_req", {31'd0, s_req0 | s_req1}, 32'd1);
          if (s_req0 && s_req1) m_win = (m_last == 0);
          else m_win = s_req1;
          m_w = m_win ? s_w1 : s_w0;
          m_y = m_win ? s_y1 : s_y0;
          m_to = (stub_lat == 0);
          m_done_n = m_to ? TB_TO + 1 : stub_lat + 2;
          m_act = 1'b1; m_n = 0;
        end else if (m_act) begin
          m_n++;
        end
        if (m_act) begin
          chk("m_w_stable", {24'd0, M_W}, {24'd0, m_w});
          chk("m_y_stable", {24'd0, M_Y}, {24'd0, m_y});
          if (ACK0 || ACK1) begin
            chk("ack_cycle", m_n, m_done_n);
            chk("ack_idx", {30'd0, ACK1, ACK0}, m_win ? 32'd2 : 32'd1);
            chk("ack_err", {31'd0, ERR}, {31'd0, m_to});
            m_res = m_to ? 16'hFFFF : 16'(m_w) * 16'(m_y);
            m_last = m_win; m_act = 1'b0; m_after = 1'b1;
          end else begin
            chk("busy_in_op", {31'd0, BUSY}, 32'd1);
            if (m_n >= m_done_n) begin
              chk("ack_by_deadline", m_n, m_done_n - 1);
              m_act = 1'b0;
            end
          end
        end else begin
          chk("no_unexpected_ack", {30'd0, ACK1, ACK0}, 32'd0);
        end
        chk("result_hold", {16'd0, RESULT}, {16'd0, m_res});
        if (!(ACK0 || ACK1)) chk("err_only_with_ack", {31'd0, ERR}, 32'd0);
      end
    end
  end

  task automatic wait_ack(input int idx, input logic [15:0] exp_res, input logic exp_err, input string nm);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!(ACK0 || ACK1) && n < 300);
    chk({nm, "_ack_seen"}, {31'd0, ACK0 | ACK1}, 32'd1);
    if (ACK0 || ACK1) begin
      chk({nm, "_idx"}, {30'd0, ACK1, ACK0}, (idx == 1) ? 32'd2 : 32'd1);
      chk({nm, "_result"}, {16'd0, RESULT}, {16'd0, exp_res});
      chk({nm, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
    end
  endtask

  task automatic wait_run(input string nm);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!M_S && n < 50);
    chk({nm, "_run_seen"}, {31'd0, M_S}, 32'd1);
  endtask

  initial begin
    RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    W0 = 8'd0; Y0 = 8'd0; W1 = 8'd0; Y1 = 8'd0;
    repeat (3) @(negedge CLK);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    chk("reset_acks", {30'd0, ACK1, ACK0}, 32'd0);
    chk("reset_err", {31'd0, ERR}, 32'd0);
    chk("reset_ms", {31'd0, M_S}, 32'd0);
    chk("reset_mreset", {31'd0, M_RESET}, 32'd1);
    chk("reset_result", {16'd0, RESULT}, 32'd0);
    chk("reset_mw_my", {16'd0, M_W, M_Y}, 32'd0);
    tb_go = 1'b1;
    @(negedge CLK); RESET = 1'b0;

    // Single request
    stub_lat = 2;
    push(0, 8'd6, 8'd10);
    wait_ack(0, 16'd60, 1'b0, "t1");
    repeat (4) @(negedge CLK);
    chk("t1_busy_back_low", {31'd0, BUSY}, 32'd0);

    // Tie straight after reset: requester 0 first
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    push(0, 8'd3, 8'd5);
    push(1, 8'd255, 8'd255);
    wait_ack(0, 16'd15, 1'b0, "t2a");
    wait_ack(1, 16'd65025, 1'b0, "t2b");

    // Fairness with both requesters permanently pending
    stub_lat = 1;
    @(negedge CLK);
    push(0, 8'd2, 8'd3);   push(0, 8'd4, 8'd5);   push(0, 8'd9, 8'd9);
    push(1, 8'd10, 8'd10); push(1, 8'd200, 8'd2); push(1, 8'd0, 8'd77);
    wait_ack(0, 16'd6, 1'b0, "t3_1");
    wait_ack(1, 16'd100, 1'b0, "t3_2");
    wait_ack(0, 16'd20, 1'b0, "t3_3");
    wait_ack(1, 16'd400, 1'b0, "t3_4");
    wait_ack(0, 16'd81, 1'b0, "t3_5");
    wait_ack(1, 16'd0, 1'b0, "t3_6");

    // Late arrival during requester 0's RUN
    stub_lat = 4;
    @(negedge CLK);
    push(0, 8'd7, 8'd9);
    wait_run("t4");
    @(negedge CLK);
    push(1, 8'd12, 8'd12);
    wait_ack(0, 16'd63, 1'b0, "t4a");
    wait_ack(1, 16'd144, 1'b0, "t4b");

    // Reset in the middle of RUN, held request re-served afterwards
    stub_lat = 5;
    @(negedge CLK);
    push(0, 8'd11, 8'd13);
    wait_run("t5");
    @(negedge CLK); RESET = 1'b1;
    #1 chk("t5_mreset", {31'd0, M_RESET}, 32'd1);
    @(negedge CLK); RESET = 1'b0;
    chk("t5_result_cleared", {16'd0, RESULT}, 32'd0);
    chk("t5_idle", {31'd0, BUSY}, 32'd0);
    chk("t5_no_ack", {30'd0, ACK1, ACK0}, 32'd0);
    wait_ack(0, 16'd143, 1'b0, "t5");

`ifdef MULT_SHARE_TIMEOUT_EN
    // Multiplier never finishes: watchdog abort, then a normal operation
    stub_lat = 0;
    @(negedge CLK);
    push(0, 8'd5, 8'd5);
    wait_ack(0, 16'hFFFF, 1'b1, "t6_timeout");
    stub_lat = 2;
    push(1, 8'd2, 8'd3);
    wait_ack(1, 16'd6, 1'b0, "t6_after");
`endif

    repeat (5) @(negedge CLK);
    chk("final_idle", {31'd0, BUSY}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one sequential 8-bit multiplier (start `S`, `RESET`, `w`/`y` in, `result`/`PRONTO` out) between two requesters. It arbitrates pending requests and latches the winner's operands. It clears and starts the multiplier, waits for `PRONTO`, then returns the registered product with a one-cycle acknowledge. It sits between the multiplier instance and the two client blocks that previously each needed their own copy.

## Interface

Parameters:
- `WIDTH`, 8: operand width; product is 2*WIDTH.
- `TIMEOUT`, 64: max RUN cycles before abort. Used only with the configuration macro.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `REQ0`, `REQ1`  in  1  request levels; held high until the matching ACK.
- `W0`, `Y0`, `W1`, `Y1`  in  WIDTH  requester operands; must be stable while REQ is high.
- `ACK0`, `ACK1`  out  1  one-cycle pulse; `RESULT` is valid in that cycle.
- `RESULT`  out  2*WIDTH  registered product; holds its value until the next ACK.
- `ERR`  out  1  one-cycle pulse coincident with ACK when the operation timed out.
- `BUSY`  out  1  high in every state except IDLE.
- `M_RESET`  out  1  multiplier reset.
- `M_S`  out  1  multiplier start.
- `M_W`, `M_Y`  out  WIDTH  multiplier operands.
- `M_RESULT`  in  2*WIDTH  multiplier product.
- `M_PRONTO`  in  1  multiplier done.

## Operation

- States: IDLE, LOAD, RUN, DONE.
- Round-robin pointer `last` records which requester was served most recently.
- **IDLE**
  - No REQ high: stay in IDLE.
  - Exactly one REQ high: grant it.
  - Both REQ high: grant the requester that is not `last`.
  - On a grant: register the winner's W/Y into `M_W`/`M_Y`, store the grant index, go to LOAD.
- **LOAD** (exactly 1 cycle): `M_RESET`=1, `M_S`=0. Go to RUN.
- **RUN**
  - `M_S`=1 throughout.
  - `M_PRONTO` is sampled only in RUN. It is ignored in IDLE and LOAD, because a stale done from the previous operation may still be present.
  - `M_PRONTO`=1 at a rising edge: capture `M_RESULT` into `RESULT`, update `last` to the grant index, go to DONE.
- **DONE** (exactly 1 cycle)
  - The ACK of the granted requester is high; `M_S`=0.
  - Go to IDLE.
- Requester protocol:
  - A requester drops REQ in the cycle after its ACK.
  - A REQ still high in IDLE after its ACK counts as a new request and is arbitrated normally.
- Requests that arrive while BUSY wait; they are arbitrated in the next IDLE cycle.
- `M_W`/`M_Y` hold their values from LOAD through DONE. Operand changes at requester inputs during an operation have no effect.
- No arithmetic is done here. `RESULT` is a straight 2*WIDTH copy of `M_RESULT`.

## Timing

- Reset values:
  - State IDLE, `last`=1, so requester 0 wins the first tie.
  - `ACK0`, `ACK1`, `ERR`, `BUSY`, `M_S` = 0.
  - `RESULT`, `M_W`, `M_Y` = 0.
  - `M_RESET` = 1 while `RESET` is high.
- `M_RESET` = `RESET` OR (state == LOAD).
- Latency: REQ sampled in IDLE at edge t → LOAD in cycle t+1 → RUN from t+2. If PRONTO is sampled at edge t+2+k, ACK is high in cycle t+3+k. The arbiter adds 3 cycles of overhead to the multiplier's run time.
- Back-to-back service: the next grant happens at the IDLE edge after DONE. Minimum 1 idle cycle between operations.
- Simultaneous new REQ and ACK in the same cycle: the new request is arbitrated in the following IDLE cycle.
- `RESET` asserted in any state:
  - Next state is IDLE; the operation is abandoned.
  - No ACK is issued; `RESULT` is cleared.
  - The multiplier is held in reset through `M_RESET`.

## Configuration

- `MULT_SHARE_TIMEOUT_EN` defined:
  - An 8-bit-or-wider cycle counter clears on entry to RUN and increments each RUN cycle.
  - If the counter reaches `TIMEOUT` with no PRONTO, go to DONE with `RESULT` = all ones and `ERR`=1 alongside the ACK.
  - PRONTO sampled high in the same cycle as the limit is reached wins: normal completion, no `ERR`.
- `MULT_SHARE_TIMEOUT_EN` undefined:
  - No counter is built.
  - RUN waits on PRONTO indefinitely.
  - `ERR` is tied to 0.

## Test plan

- Single request: after reset, REQ0=1 with W0=6, Y0=10. Required: ACK0 pulses once, `RESULT`=60, ACK1 never rises, `BUSY` returns to 0.
- Tie after reset: REQ0 and REQ1 rise in the same cycle (W0=3, Y0=5, W1=255, Y1=255). Required: ACK0 first with `RESULT`=15, then ACK1 with `RESULT`=65025.
- Fairness: both REQs held high continuously for 6 operations. Required: ACKs alternate 0,1,0,1,0,1. No requester is served twice in a row while the other is pending.
- Late arrival: REQ1 rises while requester 0's operation is in RUN (W1=12, Y1=12). Required: requester 0 completes first, then ACK1 with `RESULT`=144. `M_W`/`M_Y` do not change during requester 0's run.
- Reset mid-RUN: assert `RESET` for 1 cycle during RUN. Required: no ACK, `RESULT`=0, state IDLE. `M_RESET`=1 in that cycle, and a held REQ is re-served correctly afterwards.
- Timeout, with `MULT_SHARE_TIMEOUT_EN` defined and `TIMEOUT`=16: stub multiplier never raises PRONTO. Required: ACK0 and `ERR` pulse together after 16 RUN cycles, `RESULT`=16'hFFFF. The next request is arbitrated normally.
